// File: rtl/lemon_rf_pkg.sv
// rtl/lemon_rf_pkg.sv - shared widths and writeback source encoding for the RF write path
package lemon_rf_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 64;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;
endpackage

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-way round-robin grant between ALU and LSU writebacks
module rf_wb_arbiter
  import lemon_rf_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic alu_valid,
  input  logic lsu_valid,
  output logic grant_alu,
  output logic grant_lsu
);

  wb_src_e prio_q;
  logic    both;

  assign both = alu_valid && lsu_valid;

  // Priority only rotates on an actual conflict; a lone requester leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= WB_LSU;
    end else if (both) begin
      prio_q <= (prio_q == WB_LSU) ? WB_ALU : WB_LSU;
    end
  end

  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (!rst) begin
      if (both) begin
        grant_lsu = (prio_q == WB_LSU);
        grant_alu = (prio_q == WB_ALU);
      end else begin
        grant_alu = alu_valid;
        grant_lsu = lsu_valid;
      end
    end
  end

endmodule

// File: rtl/rf_wb_scoreboard.sv
// rtl/rf_wb_scoreboard.sv - register file write-port owner with pending-write scoreboard
module rf_wb_scoreboard
  import lemon_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int DATA_WIDTH = RF_DATA_W,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [ADDR_WIDTH-1:0]    issue_rs1,
  input  logic [ADDR_WIDTH-1:0]    issue_rs2,
  input  logic [ADDR_WIDTH-1:0]    issue_rd,
  input  logic                     issue_rd_wen,
  output logic                     issue_ready,
  input  logic                     alu_wb_valid,
  input  logic [ADDR_WIDTH-1:0]    alu_wb_rd,
  input  logic [DATA_WIDTH-1:0]    alu_wb_data,
  output logic                     alu_wb_ready,
  input  logic                     lsu_wb_valid,
  input  logic [ADDR_WIDTH-1:0]    lsu_wb_rd,
  input  logic [DATA_WIDTH-1:0]    lsu_wb_data,
  output logic                     lsu_wb_ready,
  output logic                     rf_wen,
  output logic [ADDR_WIDTH-1:0]    rf_rd,
  output logic [DATA_WIDTH-1:0]    rf_dataD,
  output logic [2**ADDR_WIDTH-1:0] busy_mask,
  output logic                     err_spurious,
  output logic [CNT_WIDTH-1:0]     stall_cnt
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [NREG-1:0]       busy_q;
  logic [NREG-1:0]       busy_set;
  logic [NREG-1:0]       busy_clr;
  logic                  grant_alu;
  logic                  grant_lsu;
  logic                  issue_fire;
  logic [ADDR_WIDTH-1:0] wb_rd;

  rf_wb_arbiter u_arb (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_wb_valid),
    .lsu_valid (lsu_wb_valid),
    .grant_alu (grant_alu),
    .grant_lsu (grant_lsu)
  );

  assign alu_wb_ready = grant_alu;
  assign lsu_wb_ready = grant_lsu;

  // busy_q[0] is never set, so x0 can never read as busy.
  assign issue_ready = !rst && !busy_q[issue_rs1] && !busy_q[issue_rs2]
                       && !(issue_rd_wen && busy_q[issue_rd]);
  assign issue_fire  = issue_valid && issue_ready;

  assign wb_rd    = grant_lsu ? lsu_wb_rd : alu_wb_rd;
  assign rf_rd    = wb_rd;
  assign rf_dataD = grant_lsu ? lsu_wb_data : alu_wb_data;
  assign rf_wen   = (grant_alu || grant_lsu) && (wb_rd != '0);

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (issue_fire && issue_rd_wen && issue_rd != '0) busy_set[issue_rd] = 1'b1;
    if (rf_wen) busy_clr[wb_rd] = 1'b1;
  end

  // Set is applied after clear so a newly issued writer survives a same-edge retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      err_spurious <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      busy_q <= (busy_q & ~busy_clr) | busy_set;
      if (rf_wen && !busy_q[wb_rd]) err_spurious <= 1'b1;
      if (issue_valid && !issue_ready && stall_cnt != {CNT_WIDTH{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign busy_mask = busy_q;

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// tb/tb_rf_wb_scoreboard.sv - self-checking bench for rf_wb_scoreboard
module tb_rf_wb_scoreboard;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int CW = 4;
  localparam int NR = 32;
  localparam int SMAX = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid, issue_rd_wen, issue_ready;
  logic [AW-1:0] issue_rs1, issue_rs2, issue_rd;
  logic          alu_wb_valid, alu_wb_ready, lsu_wb_valid, lsu_wb_ready;
  logic [AW-1:0] alu_wb_rd, lsu_wb_rd, rf_rd;
  logic [DW-1:0] alu_wb_data, lsu_wb_data, rf_dataD;
  logic          rf_wen, err_spurious;
  logic [NR-1:0] busy_mask;
  logic [CW-1:0] stall_cnt;

  rf_wb_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_rd_wen(issue_rd_wen), .issue_ready(issue_ready),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .lsu_wb_ready(lsu_wb_ready),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_dataD(rf_dataD),
    .busy_mask(busy_mask), .err_spurious(err_spurious), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference state: set of registers with a write in flight, plus flags.
  bit m_busy[NR];
  bit m_prio_lsu, m_err;
  int m_stall;
  bit m_ga, m_gl, m_ir;

  typedef struct {
    logic iv; logic [4:0] rs1, rs2, rd; logic iw;
    logic av; logic [4:0] ard; logic [7:0] ad;
    logic lv; logic [4:0] lrd; logic [7:0] ld;
    logic e_ir, e_ar, e_lr, e_wen; logic [4:0] e_rd; logic [7:0] e_d;
    logic [31:0] e_busy; logic e_err;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(logic iv, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
      logic iw, logic av, logic [4:0] ard, logic [7:0] ad, logic lv, logic [4:0] lrd,
      logic [7:0] ld, logic e_ir, logic e_ar, logic e_lr, logic e_wen, logic [4:0] e_rd,
      logic [7:0] e_d, logic [31:0] e_busy, logic e_err);
    vec_t v;
    v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.iw = iw;
    v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.e_ir = e_ir; v.e_ar = e_ar; v.e_lr = e_lr; v.e_wen = e_wen; v.e_rd = e_rd;
    v.e_d = e_d; v.e_busy = e_busy; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [NR-1:0] model_mask();
    logic [NR-1:0] m;
    for (int i = 0; i < NR; i++) m[i] = m_busy[i];
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_busy[i] = 0;
    m_prio_lsu = 1; m_err = 0; m_stall = 0;
  endtask

  task automatic model_check();
    logic [AW-1:0] wrd;
    logic [DW-1:0] wdat;
    bit wen;
    m_ir = !rst && !(issue_rs1 != 0 && m_busy[issue_rs1]) && !(issue_rs2 != 0 && m_busy[issue_rs2])
           && !(issue_rd_wen && issue_rd != 0 && m_busy[issue_rd]);
    m_ga = 0; m_gl = 0;
    if (!rst) begin
      if (alu_wb_valid && lsu_wb_valid) begin
        m_gl = m_prio_lsu; m_ga = !m_prio_lsu;
      end else begin
        m_ga = alu_wb_valid; m_gl = lsu_wb_valid;
      end
    end
    wrd  = m_gl ? lsu_wb_rd : alu_wb_rd;
    wdat = m_gl ? lsu_wb_data : alu_wb_data;
    wen  = (m_ga || m_gl) && wrd != 0;
    chk("model_issue_ready", issue_ready, m_ir);
    chk("model_alu_ready", alu_wb_ready, m_ga);
    chk("model_lsu_ready", lsu_wb_ready, m_gl);
    chk("model_rf_wen", rf_wen, wen);
    if (wen) begin
      chk("model_rf_rd", rf_rd, wrd);
      chk("model_rf_data", rf_dataD, wdat);
    end
    chk("model_busy", busy_mask, model_mask());
    chk("model_err", err_spurious, m_err);
    chk("model_stall", stall_cnt, m_stall);
  endtask

  task automatic model_update();
    logic [AW-1:0] wrd;
    if (rst) begin
      model_reset();
    end else begin
      if (issue_valid && !m_ir && m_stall < SMAX) m_stall++;
      if (m_ga || m_gl) begin
        wrd = m_gl ? lsu_wb_rd : alu_wb_rd;
        if (wrd != 0) begin
          if (!m_busy[wrd]) m_err = 1;
          m_busy[wrd] = 0;
        end
      end
      if (alu_wb_valid && lsu_wb_valid) m_prio_lsu = !m_prio_lsu;
      if (issue_valid && m_ir && issue_rd_wen && issue_rd != 0) m_busy[issue_rd] = 1;
    end
  endtask

  task automatic tick();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_rd_wen = 0;
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_data = 0;
  endtask

  function automatic logic [AW-1:0] pick_rd();
    int s;
    s = $urandom_range(0, NR - 1);
    if ($urandom_range(0, 3) != 0)
      for (int i = 0; i < NR; i++) if (m_busy[(s + i) % NR]) return AW'((s + i) % NR);
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    bit a_pend, l_pend;
    vt[0]  = mk(1,0,0,5,1, 0,0,0,     0,0,0,     1,0,0,0,0,0,     32'h0,  0);
    vt[1]  = mk(1,5,0,0,0, 0,0,0,     0,0,0,     0,0,0,0,0,0,     32'h20, 0);
    vt[2]  = mk(1,5,0,0,0, 1,5,8'h2A, 0,0,0,     0,1,0,1,5,8'h2A, 32'h20, 0);
    vt[3]  = mk(1,5,0,0,0, 0,0,0,     0,0,0,     1,0,0,0,0,0,     32'h0,  0);
    vt[4]  = mk(1,0,0,3,1, 0,0,0,     0,0,0,     1,0,0,0,0,0,     32'h0,  0);
    vt[5]  = mk(1,0,0,4,1, 0,0,0,     0,0,0,     1,0,0,0,0,0,     32'h8,  0);
    vt[6]  = mk(0,0,0,0,0, 1,3,8'h33, 1,4,8'h44, 1,0,1,1,4,8'h44, 32'h18, 0);
    vt[7]  = mk(0,0,0,0,0, 1,3,8'h33, 0,0,0,     1,1,0,1,3,8'h33, 32'h8,  0);
    vt[8]  = mk(1,0,0,6,1, 0,0,0,     0,0,0,     1,0,0,0,0,0,     32'h0,  0);
    vt[9]  = mk(1,0,0,7,1, 0,0,0,     0,0,0,     1,0,0,0,0,0,     32'h40, 0);
    vt[10] = mk(0,0,0,0,0, 1,6,8'h66, 1,7,8'h77, 1,1,0,1,6,8'h66, 32'hC0, 0);
    vt[11] = mk(0,0,0,0,0, 0,0,0,     1,7,8'h77, 1,0,1,1,7,8'h77, 32'h80, 0);
    vt[12] = mk(1,0,0,0,1, 1,0,8'hFF, 0,0,0,     1,1,0,0,0,0,     32'h0,  0);
    vt[13] = mk(0,0,0,0,0, 0,0,0,     0,0,0,     1,0,0,0,0,0,     32'h0,  0);
    vt[14] = mk(0,0,0,0,0, 0,0,0,     1,9,8'h99, 1,0,1,1,9,8'h99, 32'h0,  0);
    vt[15] = mk(0,0,0,0,0, 1,0,8'h01, 0,0,0,     1,1,0,0,0,0,     32'h0,  1);
    vt[16] = mk(0,0,0,0,0, 0,0,0,     0,0,0,     1,0,0,0,0,0,     32'h0,  1);

    // Reset held two cycles with every requester active.
    model_reset();
    rst = 1; idle();
    issue_valid = 1; issue_rd = 3; issue_rd_wen = 1;
    alu_wb_valid = 1; alu_wb_rd = 4; lsu_wb_valid = 1; lsu_wb_rd = 5;
    @(posedge clk); #1;
    #1;
    chk("rst_issue_ready", issue_ready, 0);
    chk("rst_alu_ready", alu_wb_ready, 0);
    chk("rst_lsu_ready", lsu_wb_ready, 0);
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_stall", stall_cnt, 0);
    tick();
    rst = 0;

    for (int i = 0; i < 17; i++) begin
      issue_valid = vt[i].iv; issue_rs1 = vt[i].rs1; issue_rs2 = vt[i].rs2;
      issue_rd = vt[i].rd; issue_rd_wen = vt[i].iw;
      alu_wb_valid = vt[i].av; alu_wb_rd = vt[i].ard; alu_wb_data = DW'(vt[i].ad);
      lsu_wb_valid = vt[i].lv; lsu_wb_rd = vt[i].lrd; lsu_wb_data = DW'(vt[i].ld);
      #1;
      chk($sformatf("vec%0d_issue_ready", i), issue_ready, vt[i].e_ir);
      chk($sformatf("vec%0d_alu_ready", i), alu_wb_ready, vt[i].e_ar);
      chk($sformatf("vec%0d_lsu_ready", i), lsu_wb_ready, vt[i].e_lr);
      chk($sformatf("vec%0d_rf_wen", i), rf_wen, vt[i].e_wen);
      if (vt[i].e_wen) begin
        chk($sformatf("vec%0d_rf_rd", i), rf_rd, vt[i].e_rd);
        chk($sformatf("vec%0d_rf_data", i), rf_dataD, DW'(vt[i].e_d));
      end
      chk($sformatf("vec%0d_busy", i), busy_mask, vt[i].e_busy);
      chk($sformatf("vec%0d_err", i), err_spurious, vt[i].e_err);
      tick();
    end

    // WAW on x8: four stalled cycles, the last one retiring x8, then accept.
    idle(); issue_valid = 1; issue_rd = 8; issue_rd_wen = 1;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin alu_wb_valid = 1; alu_wb_rd = 8; alu_wb_data = 64'h88; end
      #1;
      chk($sformatf("waw_stall%0d_ready", k), issue_ready, 0);
      tick();
    end
    alu_wb_valid = 0;
    chk("waw_stall_cnt", stall_cnt, 6);
    #1;
    chk("waw_accept_ready", issue_ready, 1);
    tick();
    chk("waw_rebusy", busy_mask[8], 1);

    // Reset mid-operation drops pending writes and the sticky error.
    idle(); rst = 1;
    tick();
    rst = 0;
    chk("midrst_busy", busy_mask, 0);
    chk("midrst_err", err_spurious, 0);
    chk("midrst_stall", stall_cnt, 0);

    // Stall counter saturates rather than wrapping.
    issue_valid = 1; issue_rd = 2; issue_rd_wen = 1;
    tick();
    issue_rs1 = 2; issue_rd = 0; issue_rd_wen = 0;
    for (int k = 0; k < 20; k++) tick();
    chk("stall_saturate", stall_cnt, SMAX);
    idle(); alu_wb_valid = 1; alu_wb_rd = 2; alu_wb_data = 64'h22;
    tick();
    idle();
    tick();

    // Random traffic against the reference model; sources hold until granted.
    a_pend = 0; l_pend = 0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (rst) begin a_pend = 0; l_pend = 0; end
      issue_valid = 1'($urandom_range(0, 1));
      issue_rs1 = AW'($urandom_range(0, 7));
      issue_rs2 = AW'($urandom_range(0, 7));
      issue_rd = AW'($urandom_range(0, 7));
      issue_rd_wen = 1'($urandom_range(0, 1));
      if (!rst && !a_pend && $urandom_range(0, 1) == 1) begin
        alu_wb_rd = pick_rd(); alu_wb_data = {$urandom, $urandom}; a_pend = 1;
      end
      if (!rst && !l_pend && $urandom_range(0, 1) == 1) begin
        lsu_wb_rd = pick_rd(); lsu_wb_data = {$urandom, $urandom}; l_pend = 1;
      end
      alu_wb_valid = a_pend;
      lsu_wb_valid = l_pend;
      tick();
      if (m_ga) a_pend = 0;
      if (m_gl) l_pend = 0;
    end
    rst = 0; idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
